sf_mc: RTL and testbench
========================

# sf_mc

Multi-channel sample fetcher: the parametrised successor of the single-channel SF block. On a `start` pulse it scans ADC channels 0..NCH-1 in order. For each channel it requests a frame, collects the `len` words the ADC returns, and buffers them in an internal FIFO. The FIFO drains through a valid/ready stream tagged with channel number and end-of-frame. It sits between the ADC front-end and the downstream sample consumer.

## Interface
Parameters:
- `DW`, 8: ADC data width.
- `LW`, 8: frame-length field width.
- `NCH`, 4: channels per scan, ≥1; `CW = max(1,$clog2(NCH))`.
- `DEPTH`, 16: output FIFO depth, power of two, ≥2.
- `TIMEOUT`, 255: idle cycles tolerated while waiting for `rdy` (used only with `SF_TIMEOUT_EN`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a scan when sampled high in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until the DONE state ends.
- `done`  out  1  one-cycle pulse when a scan completes.
- `req`  out  1  frame request to the ADC.
- `ch`  out  CW  channel select; stable whenever `req` is high.
- `rdy`  in  1  ADC word strobe, one word per high cycle; no backpressure.
- `dat`  in  DW  ADC word, valid when `rdy` is high.
- `len`  in  LW  frame word count, sampled with the first `rdy` of a frame.
- `o_valid` out 1, `o_ready` in 1, `o_dat` out DW, `o_ch` out CW, `o_last` out 1: output stream; `o_last` marks the final word of a frame.
- `ovf`  out  1  sticky: a word was dropped because the FIFO was full.
- `err`  out  1  sticky: a timeout occurred (tied 0 when the macro is off).

## Operation
- States: IDLE, REQ, RECV, GAP, DONE.
- IDLE: `req` is 0. When `start` is high, go to REQ, set `ch` to 0, and clear `ovf` and `err`.
- REQ: `req` is 1. The first `rdy` latches `len`. A latched `len` of 0 is treated as 1. The word is written to the FIFO with count=1. Go to RECV, or straight to GAP if the effective length is 1.
- RECV: `req` stays 1. Each `rdy` writes a word and increments the count (LW bits). When count equals the effective length, that word carries `o_last`=1 and the FSM goes to GAP.
- GAP: `req` is 0 for exactly one cycle. If `ch` is NCH-1, go to DONE; otherwise increment `ch` and go to REQ.
- DONE: `done` is 1 for one cycle, then go to IDLE.
- Any `rdy` seen in IDLE, GAP or DONE is ignored.
- `start` while `busy` is high is ignored.
- FIFO full and `rdy` in the same cycle: the word is dropped, `ovf` is set, and the frame count still advances, so frame framing is preserved.
- FIFO push and pop in the same cycle while full: the pop frees the slot and the push is accepted; no overflow.
- Stream rules: once `o_valid` rises, `o_dat`, `o_ch` and `o_last` stay stable until `o_ready` is high. Words are delivered in arrival order.

## Timing
- Reset values:
  - state IDLE; `req` 0, `ch` 0, `busy` 0, `done` 0, `ovf` 0, `err` 0, `o_valid` 0.
  - `o_dat`, `o_ch` and `o_last` are 0; FIFO empty.
- Reset asserted mid-scan aborts immediately; all buffered words are discarded.
- `start` high at edge N puts `req` high from N+1.
- A `rdy` at edge N is visible at the output with `o_valid` high from N+1 if the FIFO was empty (one-cycle latency).
- The last-word `rdy` at edge N drops `req` from N+1. The next channel's `req` rises at N+2.
- `done` pulses two cycles after the final `rdy` of channel NCH-1.

## Configuration
- `SF_TIMEOUT_EN` defined:
  - In REQ and RECV, a cycle counter is reset on entry and on each `rdy`.
  - When it reaches `TIMEOUT` without a `rdy`, `err` is set and the partial frame is abandoned. No `o_last` is emitted for it.
  - The FSM goes to GAP, and the scan continues with the next channel.
- `SF_TIMEOUT_EN` undefined: no counter; the FSM waits indefinitely and `err` is constant 0.

## Structure
- Shared package `sf_pkg`: the state enum typedef, a FIFO entry struct {dat, ch, last}, and default parameter constants.
- One sub-module, `sf_fifo`: synchronous FIFO with full/empty flags, DEPTH entries of the entry struct, and the same `clk`/`rst`.

## Test plan
- NCH=4, `len`=3 on every channel, `o_ready`=1 -> 12 words out, `o_ch` sequence 0,0,0,1,…,3, `o_last` on words 3/6/9/12, one `done` pulse.
- `len`=0 on channel 2 -> exactly one word for ch 2, with `o_last`=1.
- `o_ready`=0, DEPTH=16, 4×`len`=5 -> 16 words held, 4 dropped, `ovf`=1; after `o_ready`=1 the first 16 words arrive intact and in order.
- `start` pulsed mid-scan -> ignored; a single `done`. `start` repeated after `done` -> `ovf` and `err` cleared, new scan runs.
- Reset pulsed during RECV of ch 1 -> `req`, `busy` and `o_valid` are 0 immediately; the next `start` begins at ch 0.
- With `SF_TIMEOUT_EN` and TIMEOUT=20, ch 1 silent -> `err`=1 after 20 cycles, ch 2 requested, scan completes with `done`.

Source files
------------

// File: rtl/sf_pkg.sv
// sf_pkg: shared types and default constants for the multi-channel
// sample fetcher (FSM state enum, FIFO entry record, defaults).
package sf_pkg;

    localparam int SF_DW      = 8;
    localparam int SF_LW      = 8;
    localparam int SF_NCH     = 4;
    localparam int SF_DEPTH   = 16;
    localparam int SF_TIMEOUT = 255;

    // Channel-number width for a given channel count, never below one bit.
    function automatic int sf_cw(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    localparam int SF_CW = sf_cw(SF_NCH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_GAP,
        S_DONE
    } sf_state_e;

    typedef struct packed {
        logic [SF_DW-1:0] dat;
        logic [SF_CW-1:0] ch;
        logic             last;
    } sf_entry_t;

endpackage

// File: rtl/sf_fifo.sv
// sf_fifo: synchronous FIFO of DEPTH entries; a pop frees a slot for a
// push in the same cycle. Read data reads as zero while empty.
module sf_fifo
    import sf_pkg::*;
#(
    parameter type T     = sf_entry_t,
    parameter int  DEPTH = SF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW:0]    wptr_q;
    logic [AW:0]    rptr_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                     (wptr_q[AW] != rptr_q[AW]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head entry, forced to zero when nothing is buffered
    always_comb begin
        rdata_o = '0;
        if (!empty_o) rdata_o = mem_q[rptr_q[AW-1:0]];
    end

    // Read/write pointers with a wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // Storage array; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/sf_mc.sv
// sf_mc: multi-channel sample fetcher; scans channels 0..NCH-1, buffers
// frames in sf_fifo. Define SF_TIMEOUT_EN to enable the rdy watchdog.
module sf_mc
    import sf_pkg::*;
#(
    parameter  int DW      = SF_DW,
    parameter  int LW      = SF_LW,
    parameter  int NCH     = SF_NCH,
    parameter  int DEPTH   = SF_DEPTH,
    parameter  int TIMEOUT = SF_TIMEOUT,
    localparam int CW      = sf_cw(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          req,
    output logic [CW-1:0] ch,
    input  logic          rdy,
    input  logic [DW-1:0] dat,
    input  logic [LW-1:0] len,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_dat,
    output logic [CW-1:0] o_ch,
    output logic          o_last,
    output logic          ovf,
    output logic          err
);

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [CW-1:0] ch;
        logic          last;
    } entry_t;

    sf_state_e     state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic [LW-1:0] eff_len;
    logic [LW-1:0] cnt_nx;
    logic          wr_en;
    entry_t        wr_ent;
    entry_t        rd_ent;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          tmo;

    assign eff_len = (len == '0) ? LW'(1) : len;
    assign cnt_nx  = cnt_q + LW'(1);
    assign pop     = o_valid & o_ready;

    assign req     = (state_q == S_REQ) || (state_q == S_RECV);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign ch      = ch_q;
    assign ovf     = ovf_q;
    assign err     = err_q;
    assign o_valid = ~fifo_empty;
    assign o_dat   = rd_ent.dat;
    assign o_ch    = rd_ent.ch;
    assign o_last  = rd_ent.last;

`ifdef SF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmr_q, tmr_d;

    assign tmo = req & ~rdy & (tmr_q == TW'(TIMEOUT - 1));

    // Idle-cycle count; restarts on every state change and every word
    always_comb begin
        tmr_d = '0;
        if (req && !rdy && state_d == state_q) tmr_d = tmr_q + TW'(1);
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmr_q <= '0;
        else      tmr_q <= tmr_d;
    end
`else
    // No watchdog: the FSM waits for rdy forever (never true when legal)
    assign tmo = (TIMEOUT < 0);
`endif

    // Scan sequencing, frame counting and FIFO write generation
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        wr_ent.dat  = dat;
        wr_ent.ch   = ch_q;
        wr_ent.last = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    ch_d    = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_REQ: begin
                if (rdy) begin
                    wr_en       = 1'b1;
                    wr_ent.last = (eff_len == LW'(1));
                    cnt_d       = LW'(1);
                    len_d       = eff_len;
                    state_d     = (eff_len == LW'(1)) ? S_GAP : S_RECV;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_RECV: begin
                if (rdy) begin
                    wr_en       = 1'b1;
                    wr_ent.last = (cnt_nx == len_q);
                    cnt_d       = cnt_nx;
                    if (cnt_nx == len_q) state_d = S_GAP;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (ch_q == CW'(NCH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = S_REQ;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A full FIFO with no pop drops the word; framing still advances
        if (wr_en && fifo_full && !pop) ovf_d = 1'b1;
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    sf_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_en),
        .wdata_i (wr_ent),
        .pop_i   (pop),
        .rdata_o (rd_ent),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_sf_mc.sv
// tb_sf_mc: directed, table-driven bench for sf_mc (NCH=4, DEPTH=16)
// with hand sequences for timing, reset abort and the watchdog.
module tb_sf_mc;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] dat = '0;
    logic [7:0] len = '0;
    logic       o_ready = 1'b0;
    logic       busy, done, req, ovf, err;
    logic       o_valid, o_last;
    logic [1:0] ch, o_ch;
    logic [7:0] o_dat;

    always #5 clk = ~clk;

    sf_mc #(
        .DW(8), .LW(8), .NCH(4), .DEPTH(16), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .req(req), .ch(ch), .rdy(rdy), .dat(dat), .len(len),
        .o_valid(o_valid), .o_ready(o_ready), .o_dat(o_dat),
        .o_ch(o_ch), .o_last(o_last), .ovf(ovf), .err(err)
    );

    typedef struct {
        logic [31:0] lens;
        int          silent;
        bit          hold;
        bit          mid;
        int          exp_words;
        int          exp_lasts;
        bit          exp_ovf;
        bit          exp_err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  len_tab [4];
    bit          adc_en = 1'b0;
    int          silent_ch = -1;
    int          adc_seq = 0;
    logic [10:0] got_q [$];
    int          done_cnt = 0;
    bit          stall_q = 1'b0;
    logic [10:0] stall_w = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ADC model: one word per cycle while req is high
    initial forever begin
        @(negedge clk);
        if (adc_en) begin
            if (req && int'(ch) != silent_ch) begin
                rdy = 1'b1;
                dat = adc_seq[7:0];
                len = len_tab[ch];
                adc_seq++;
            end else begin
                rdy = 1'b0;
            end
        end
    end

    // Output monitor: records transfers, checks hold-under-stall
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                chk("stream_hold", {o_valid, o_dat, o_ch, o_last},
                    {1'b1, stall_w});
            if (done) done_cnt++;
            if (o_valid && o_ready) got_q.push_back({o_dat, o_ch, o_last});
            stall_q = o_valid && !o_ready;
            stall_w = {o_dat, o_ch, o_last};
        end
    end

    task automatic run_case(input vec_t v, input string nm);
        logic [10:0] exp_q [$];
        int seq = 0;
        int n = 0;
        int lasts = 0;
        int l;
        for (int c = 0; c < 4; c++) len_tab[c] = v.lens[c*8 +: 8];
        silent_ch = v.silent;
        adc_seq = 0;
        done_cnt = 0;
        got_q.delete();
        o_ready = !v.hold;
        adc_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_ovf_clr"}, ovf, 0);
        if (v.mid) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_finish"}, n < 2000, 1);
        if (v.hold) begin
            chk({nm, "_held"}, got_q.size(), 0);
            @(negedge clk);
            o_ready = 1'b1;
        end
        repeat (24) @(negedge clk);
        adc_en = 1'b0;
        rdy = 1'b0;
        chk({nm, "_ovf"}, ovf, v.exp_ovf);
        chk({nm, "_err"}, err, v.exp_err);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_words"}, got_q.size(), v.exp_words);
        for (int c = 0; c < 4; c++) begin
            if (c != v.silent) begin
                l = (len_tab[c] == 0) ? 1 : int'(len_tab[c]);
                for (int k = 1; k <= l; k++) begin
                    exp_q.push_back({seq[7:0], c[1:0], k == l});
                    seq++;
                end
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_w%0d", nm, i), got_q[i], exp_q[i]);
            if (got_q[i][0]) lasts++;
        end
        chk({nm, "_lasts"}, lasts, v.exp_lasts);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab [6];
        vec_t rv;
        int   n;
        tab[0] = '{32'h03030303, -1, 1'b0, 1'b0, 12, 4, 1'b0, 1'b0};
        tab[1] = '{32'h03000303, -1, 1'b0, 1'b0, 10, 4, 1'b0, 1'b0};
        tab[2] = '{32'h05050505, -1, 1'b1, 1'b0, 16, 3, 1'b1, 1'b0};
        tab[3] = '{32'h03030303, -1, 1'b0, 1'b1, 12, 4, 1'b0, 1'b0};
        tab[4] = '{32'h04000201, -1, 1'b0, 1'b0,  8, 4, 1'b0, 1'b0};
        tab[5] = '{32'h00000000, -1, 1'b0, 1'b0,  4, 4, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", {req, busy, done, ovf, err, o_valid, o_last}, 0);
        chk("rst_ch", {ch, o_ch, o_dat}, 0);
        @(negedge clk);
        rst = 1'b1;
        o_ready = 1'b1;

        @(negedge clk);
        rdy = 1'b1;
        dat = 8'h5A;
        len = 8'd1;
        @(negedge clk);
        rdy = 1'b0;
        chk("rdy_idle_ignored", o_valid, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_req", {req, busy, ch}, {1'b1, 1'b1, 2'd0});
        @(negedge clk);
        start = 1'b0;
        rdy = 1'b1;
        dat = 8'hA1;
        len = 8'd1;
        @(posedge clk);
        #1;
        chk("lat1_word", {o_valid, o_dat, o_ch, o_last},
            {1'b1, 8'hA1, 2'd0, 1'b1});
        chk("gap_req_low", req, 0);
        @(negedge clk);
        rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("next_ch_req", {req, ch}, {1'b1, 2'd1});
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            rdy = 1'b1;
            dat = 8'(c);
            @(negedge clk);
            rdy = 1'b0;
        end
        chk("done_gap", {done, req}, 0);
        @(negedge clk);
        chk("done_pulse", {done, busy}, 2'b11);
        @(negedge clk);
        chk("done_end", {done, busy}, 0);

        for (int i = 0; i < 6; i++) run_case(tab[i], $sformatf("tab%0d", i));

        len_tab = '{8'd3, 8'd3, 8'd3, 8'd3};
        silent_ch = -1;
        adc_seq = 0;
        o_ready = 1'b0;
        adc_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(req && ch == 2'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_ch1", n < 100, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_abort", {req, busy, o_valid, ch}, 0);
        adc_en = 1'b0;
        rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rv = '{32'h01010101, -1, 1'b0, 1'b0, 4, 4, 1'b0, 1'b0};
        run_case(rv, "post_rst");

`ifdef SF_TIMEOUT_EN
        rv = '{32'h02020202, 1, 1'b0, 1'b0, 6, 3, 1'b0, 1'b1};
        run_case(rv, "tmo");
        run_case(tab[0], "after_tmo");
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
